// File: rtl/rob_commit_unit_if.sv
// Rename/commit bus between the reorder buffer and its neighbours.
// Groups the issue, rename, CDB, operand-query and commit signals.
// The master modport is the reorder buffer; the slave modport is the environment.
interface rob_commit_unit_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned Q_WIDTH        = 5
);

  // Issue and rename
  logic                      issue_valid;
  logic                      issue_has_rd;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic [Q_WIDTH-1:0]        issue_tag;
  logic                      rob_full;
  logic                      rd_control;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [Q_WIDTH-1:0]        Q_value;

  // Common data bus
  logic                      cdb_valid;
  logic [Q_WIDTH-1:0]        cdb_tag;
  logic [31:0]               cdb_value;

  // Operand readiness queries
  logic [Q_WIDTH-1:0]        query_q1;
  logic [Q_WIDTH-1:0]        query_q2;
  logic                      q1_ready;
  logic                      q2_ready;
  logic [31:0]               q1_value;
  logic [31:0]               q2_value;

  // In-order commit to the register file
  logic                      has_commit;
  logic [REG_ADDR_WIDTH-1:0] commit_target;
  logic [Q_WIDTH-1:0]        Commit_Q;
  logic [31:0]               Commit_V;

  modport master (
    input  issue_valid, issue_has_rd, issue_rd,
    input  cdb_valid, cdb_tag, cdb_value,
    input  query_q1, query_q2,
    output issue_tag, rob_full, rd_control, rd, Q_value,
    output q1_ready, q2_ready, q1_value, q2_value,
    output has_commit, commit_target, Commit_Q, Commit_V
  );

  modport slave (
    output issue_valid, issue_has_rd, issue_rd,
    output cdb_valid, cdb_tag, cdb_value,
    output query_q1, query_q2,
    input  issue_tag, rob_full, rd_control, rd, Q_value,
    input  q1_ready, q2_ready, q1_value, q2_value,
    input  has_commit, commit_target, Commit_Q, Commit_V
  );

endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates tags at issue, drives rename requests, captures CDB
// results, answers operand queries and retires entries strictly in order.
// Optional macro ROB_BYPASS_EN: operand queries also hit the same-cycle CDB broadcast.
// Tag encoding: tag = entry index + 1, tag 0 means "no producer".
module rob_commit_unit #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned PTR_WIDTH      = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned Q_WIDTH        = 5
) (
  input logic              clk_in,
  input logic              rst_n_in,
  input logic              rdy_in,
  input logic              flush_in,
  rob_commit_unit_if.master bus
);

  localparam logic [PTR_WIDTH:0] CountFull = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [Q_WIDTH-1:0] TagMax    = Q_WIDTH'(DEPTH);

  // Entry state: control bits reset, payload does not need to
  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          ready_q;
  logic [DEPTH-1:0]          has_rd_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q    [DEPTH];
  logic [31:0]               value_q [DEPTH];

  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;

  logic                 rob_full;
  logic                 issue_ok;
  logic                 issue_fire;
  logic                 commit_fire;
  logic [PTR_WIDTH-1:0] cdb_idx;
  logic                 cdb_hit;

  // Returns {ready, value} for an operand tag
  function automatic logic [32:0] lookup(input logic [Q_WIDTH-1:0] tag);
    logic [PTR_WIDTH-1:0] idx;
    logic [32:0]          res;
    idx = PTR_WIDTH'(tag - Q_WIDTH'(1));
    if (tag == '0) begin
      res = {1'b1, 32'h0};
    end else if (tag > TagMax) begin
      res = '0;
    end else begin
      res = {valid_q[idx] & ready_q[idx], value_q[idx]};
    end
`ifdef ROB_BYPASS_EN
    if ((tag != '0) && bus.cdb_valid && (bus.cdb_tag == tag)) begin
      res = {1'b1, bus.cdb_value};
    end
`endif
    return res;
  endfunction

  // Issue acceptance, rename request and CDB/commit qualification
  always_comb begin
    rob_full       = (count_q == CountFull);
    issue_ok       = bus.issue_valid & ~rob_full & ~flush_in;
    issue_fire     = issue_ok & rdy_in;
    bus.rob_full   = rob_full;
    bus.issue_tag  = Q_WIDTH'(tail_q) + Q_WIDTH'(1);
    bus.Q_value    = Q_WIDTH'(tail_q) + Q_WIDTH'(1);
    bus.rd         = bus.issue_rd;
    bus.rd_control = issue_ok & bus.issue_has_rd & (bus.issue_rd != '0);
    cdb_idx        = PTR_WIDTH'(bus.cdb_tag - Q_WIDTH'(1));
    // Out-of-range or zero tags and stale (invalid) entries are ignored
    cdb_hit        = bus.cdb_valid & (bus.cdb_tag != '0) & (bus.cdb_tag <= TagMax) &
                     valid_q[cdb_idx];
    commit_fire    = valid_q[head_q] & ready_q[head_q];
  end

  // Operand queries from the register file
  always_comb begin
    {bus.q1_ready, bus.q1_value} = lookup(bus.query_q1);
    {bus.q2_ready, bus.q2_value} = lookup(bus.query_q2);
  end

  // Pointer and occupancy next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (issue_fire) begin
      tail_d = tail_q + PTR_WIDTH'(1);
    end
    if (commit_fire) begin
      head_d = head_q + PTR_WIDTH'(1);
    end
    case ({issue_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and entry control bits; flush wins over issue, CDB and commit
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        valid_q <= '0;
        ready_q <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        // Issue targets an invalid slot, commit a valid one, so they never collide
        if (issue_fire) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
        end
        if (cdb_hit) begin
          ready_q[cdb_idx] <= 1'b1;
        end
        if (commit_fire) begin
          valid_q[head_q] <= 1'b0;
        end
      end
    end
  end

  // Entry payload: destination info at issue, result value on CDB capture
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      if (issue_fire) begin
        has_rd_q[tail_q] <= bus.issue_has_rd;
        rd_q[tail_q]     <= bus.issue_rd;
      end
      if (cdb_hit) begin
        value_q[cdb_idx] <= bus.cdb_value;
      end
    end
  end

  // Registered commit port; has_commit is a one-cycle pulse per retire
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.has_commit    <= 1'b0;
      bus.commit_target <= '0;
      bus.Commit_Q      <= '0;
      bus.Commit_V      <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        bus.has_commit <= 1'b0;
      end else begin
        bus.has_commit <= commit_fire & has_rd_q[head_q] & (rd_q[head_q] != '0);
        if (commit_fire) begin
          bus.commit_target <= rd_q[head_q];
          bus.Commit_Q      <= Q_WIDTH'(head_q) + Q_WIDTH'(1);
          bus.Commit_V      <= value_q[head_q];
        end
      end
    end
  end

endmodule
